// File: rtl/iccm_boot_loader.sv
// ============================================================================
// Module      : iccm_boot_loader
// Description : Packs UART bytes MSB-first into 32-bit words and writes them
//               to sequential ICCM addresses; releases the core on terminator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iccm_boot_loader #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] END_WORD   = 32'h0000_0FFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_dv_i,
    input  logic [7:0]            rx_byte_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  core_reset_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [0:0]            c_LOAD     = 1'b0;
    localparam logic [0:0]            c_DONE     = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [1:0]            c_LAST_BYTE = 2'd3;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [1:0]            r_byte_cnt;
    logic [23:0]           r_shift;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;

    logic [31:0]           w_word;
    logic                  w_word_done;
    logic                  w_is_end;
    logic                  w_cap_hit;

    assign w_word      = {r_shift, rx_byte_i};
    assign w_word_done = (r_state == c_LOAD) && rx_dv_i && (r_byte_cnt == c_LAST_BYTE);
    assign w_is_end    = (w_word == END_WORD);
    // Write landing on the last address: memory is full, stop accepting words.
    assign w_cap_hit   = (r_state == c_LOAD) && r_we && (r_addr == c_ADDR_MAX);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_LOAD: begin
                if (w_cap_hit || (w_word_done && w_is_end)) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE:  w_state_nxt = c_DONE;
            default: w_state_nxt = c_LOAD;
        endcase
    end

    // Output decode
    always_comb begin
        core_reset_o = 1'b1;
        done_o       = 1'b0;
        case (r_state)
            c_LOAD: begin
                core_reset_o = 1'b1;
                done_o       = 1'b0;
            end
            c_DONE: begin
                core_reset_o = 1'b0;
                done_o       = 1'b1;
            end
            default: begin
                core_reset_o = 1'b1;
                done_o       = 1'b0;
            end
        endcase
    end

    // Byte assembly and write port; wdata is held apart from the shifter so
    // bytes arriving during a write pulse cannot disturb the word in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_we && (r_addr != c_ADDR_MAX)) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_cap_hit) begin
                r_err <= 1'b1;
            end else if ((r_state == c_LOAD) && rx_dv_i) begin
                if (r_byte_cnt != c_LAST_BYTE) begin
                    r_shift    <= w_word[23:0];
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end else begin
                    r_byte_cnt <= 2'd0;
                    if (!w_is_end) begin
                        r_we    <= 1'b1;
                        r_wdata <= w_word[DATA_WIDTH-1:0];
                    end
                end
            end
        end
    end

    assign we_o    = r_we;
    assign addr_o  = r_addr;
    assign wdata_o = r_wdata;
    assign err_o   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_iccm_boot_loader.sv
// ============================================================================
// Module      : tb_iccm_boot_loader
// Description : Directed bench for iccm_boot_loader (default and 2-bit address).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iccm_boot_loader;

    logic        clk;
    logic        rst;
    logic        rx_dv;
    logic [7:0]  rx_byte;

    logic        we_l, core_reset_l, done_l, err_l;
    logic [11:0] addr_l;
    logic [31:0] wdata_l;

    logic        we_s, core_reset_s, done_s, err_s;
    logic [1:0]  addr_s;
    logic [31:0] wdata_s;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] q_addr_l[$];
    logic [31:0] q_data_l[$];
    logic [1:0]  q_addr_s[$];
    logic [31:0] q_data_s[$];
    int          wide_l = 0;
    int          wide_s = 0;
    logic        prev_we_l = 1'b0;
    logic        prev_we_s = 1'b0;

    iccm_boot_loader u_dut (
        .clock        (clk),
        .reset        (rst),
        .rx_dv_i      (rx_dv),
        .rx_byte_i    (rx_byte),
        .we_o         (we_l),
        .addr_o       (addr_l),
        .wdata_o      (wdata_l),
        .core_reset_o (core_reset_l),
        .done_o       (done_l),
        .err_o        (err_l)
    );

    iccm_boot_loader #(.ADDR_WIDTH(2)) u_dut_small (
        .clock        (clk),
        .reset        (rst),
        .rx_dv_i      (rx_dv),
        .rx_byte_i    (rx_byte),
        .we_o         (we_s),
        .addr_o       (addr_s),
        .wdata_o      (wdata_s),
        .core_reset_o (core_reset_s),
        .done_o       (done_s),
        .err_o        (err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitors: log every pulse, flag any pulse longer than one cycle.
    always @(negedge clk) begin
        if (we_l) begin
            q_addr_l.push_back(addr_l);
            q_data_l.push_back(wdata_l);
            if (prev_we_l) wide_l++;
        end
        if (we_s) begin
            q_addr_s.push_back(addr_s);
            q_data_s.push_back(wdata_s);
            if (prev_we_s) wide_s++;
        end
        prev_we_l = we_l;
        prev_we_s = we_s;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_log();
        q_addr_l.delete();
        q_data_l.delete();
        q_addr_s.delete();
        q_data_s.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        rx_dv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    // Four strobes on consecutive cycles; leaves rx_dv high for chaining.
    task automatic drive_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            rx_dv   = 1'b1;
            rx_byte = w[8*i +: 8];
        end
    endtask

    task automatic idle();
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_we"},    64'(we_l),         64'd0);
        check_eq({tag, "_addr"},  64'(addr_l),       64'd0);
        check_eq({tag, "_wdata"}, 64'(wdata_l),      64'd0);
        check_eq({tag, "_crst"},  64'(core_reset_l), 64'd1);
        check_eq({tag, "_done"},  64'(done_l),       64'd0);
        check_eq({tag, "_err"},   64'(err_l),        64'd0);
    endtask

    logic [11:0] snap_addr;
    logic [31:0] snap_wdata;
    int          snap_size;

    initial begin
        rst     = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;

        // Single word then terminator
        do_reset();
        check_reset_state("rst");
        drive_word(32'h0000_0113);
        idle();
        check_eq("t1_we",    64'(we_l),    64'd1);
        check_eq("t1_addr",  64'(addr_l),  64'd0);
        check_eq("t1_wdata", 64'(wdata_l), 64'h0000_0113);
        @(negedge clk);
        check_eq("t1_we_fall", 64'(we_l),   64'd0);
        check_eq("t1_addr_inc", 64'(addr_l), 64'd1);
        drive_word(32'h0000_0FFF);
        idle();
        @(negedge clk);
        check_eq("t1_done",  64'(done_l),       64'd1);
        check_eq("t1_crst",  64'(core_reset_l), 64'd0);
        check_eq("t1_addr_end", 64'(addr_l),    64'd1);
        check_eq("t1_nwrites", 64'(q_addr_l.size()), 64'd1);
        check_eq("t1_err",   64'(err_l),        64'd0);

        // Back-to-back words; byte strobes overlap each write pulse
        do_reset();
        drive_word(32'hDEAD_BEEF);
        drive_word(32'h1234_5678);
        drive_word(32'hCAFE_F00D);
        drive_word(32'h0000_0FFF);
        idle();
        repeat (2) @(negedge clk);
        check_eq("t2_nwrites", 64'(q_addr_l.size()), 64'd3);
        check_eq("t2_a0", 64'(q_addr_l[0]), 64'd0);
        check_eq("t2_d0", 64'(q_data_l[0]), 64'hDEAD_BEEF);
        check_eq("t2_a1", 64'(q_addr_l[1]), 64'd1);
        check_eq("t2_d1", 64'(q_data_l[1]), 64'h1234_5678);
        check_eq("t2_a2", 64'(q_addr_l[2]), 64'd2);
        check_eq("t2_d2", 64'(q_data_l[2]), 64'hCAFE_F00D);
        check_eq("t2_err",  64'(err_l),  64'd0);
        check_eq("t2_done", 64'(done_l), 64'd1);
        check_eq("t2_addr", 64'(addr_l), 64'd3);

        // Capacity exhaustion on the 2-bit instance
        do_reset();
        drive_word(32'h1111_1111);
        drive_word(32'h2222_2222);
        drive_word(32'h3333_3333);
        drive_word(32'h4444_4444);
        idle();
        check_eq("t4_we_last", 64'(we_s),   64'd1);
        check_eq("t4_addr_last", 64'(addr_s), 64'd3);
        check_eq("t4_done_pre", 64'(done_s), 64'd0);
        @(negedge clk);
        check_eq("t4_done", 64'(done_s),       64'd1);
        check_eq("t4_err",  64'(err_s),        64'd1);
        check_eq("t4_crst", 64'(core_reset_s), 64'd0);
        check_eq("t4_addr_hold", 64'(addr_s),  64'd3);
        drive_word(32'h5555_5555);
        idle();
        repeat (2) @(negedge clk);
        check_eq("t4_nwrites", 64'(q_addr_s.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t4_a%0d", i), 64'(q_addr_s[i]), 64'(i));
            check_eq($sformatf("t4_d%0d", i), 64'(q_data_s[i]), 64'(32'h1111_1111 * (i + 1)));
        end
        check_eq("t4_wdata_hold", 64'(wdata_s), 64'h4444_4444);

        // Reset during a pending write, then mid-word
        do_reset();
        drive_word(32'h1122_3344);
        idle();
        check_eq("t5_we_pend", 64'(we_l), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("t5_midwr");
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("t5_midword");
        clear_log();
        drive_word(32'h0000_0093);
        idle();
        check_eq("t5_we",    64'(we_l),    64'd1);
        check_eq("t5_addr",  64'(addr_l),  64'd0);
        check_eq("t5_wdata", 64'(wdata_l), 64'h0000_0093);

        // DONE ignores all traffic
        drive_word(32'h0000_0FFF);
        idle();
        @(negedge clk);
        check_eq("t6_done", 64'(done_l), 64'd1);
        snap_addr  = addr_l;
        snap_wdata = wdata_l;
        snap_size  = q_addr_l.size();
        drive_word(32'hA5C3_0001);
        drive_word(32'h0000_0FFF);
        idle();
        repeat (2) @(negedge clk);
        check_eq("t6_nwrites", 64'(q_addr_l.size()), 64'(snap_size));
        check_eq("t6_addr",  64'(addr_l),  64'(snap_addr));
        check_eq("t6_wdata", 64'(wdata_l), 64'(snap_wdata));
        check_eq("t6_done2", 64'(done_l),  64'd1);
        check_eq("t6_err",   64'(err_l),   64'd0);
        check_eq("t6_addr_val", 64'(addr_l), 64'd1);

        check_eq("wide_pulse_l", 64'(wide_l), 64'd0);
        check_eq("wide_pulse_s", 64'(wide_s), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
